// File: rtl/mod_updown_counter_param.sv
// Parametrised up/down modulo counter with synchronous clear and parallel
// load. Wraps or saturates at either end. terminal/carry are combinational so
// that stages chain carry -> enable into multi-digit timers with no added delay.
// wrapped and load_err are registered one-cycle pulses.
module mod_updown_counter_param #(
    parameter int MAX_VALUE   = 9,
    parameter int SATURATE    = 0,
    parameter int RESET_VALUE = 0,
    localparam int W          = $clog2(MAX_VALUE + 1)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         enable,
    input  logic         up_down,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic [W-1:0] Q,
    output logic         terminal,
    output logic         carry,
    output logic         wrapped,
    output logic         load_err
);

    // All compares and loads use the W-bit forms of the parameters.
    localparam logic [W-1:0] MAX_Q = W'(MAX_VALUE);
    localparam logic [W-1:0] RST_Q = W'(RESET_VALUE);
    localparam logic [W-1:0] ZERO_Q = '0;
    localparam logic [W-1:0] ONE_Q = W'(1);

    logic [W-1:0] q_reg;
    logic [W-1:0] q_next;
    logic         wrapped_reg;
    logic         wrapped_next;
    logic         load_err_reg;
    logic         load_err_next;

    logic         at_max;
    logic         at_zero;
    logic         q_illegal;

    assign at_max    = (q_reg == MAX_Q);
    assign at_zero   = (q_reg == ZERO_Q);
    assign q_illegal = (q_reg > MAX_Q);

    // Next-state selection: clear beats load, load beats enable, else hold.
    // The pulse flags default to 0 so they only last the cycle that sets them.
    always_comb begin
        q_next        = q_reg;
        wrapped_next  = 1'b0;
        load_err_next = 1'b0;
        if (clear) begin
            q_next = ZERO_Q;
        end else if (load) begin
            if (load_value > MAX_Q) begin
                q_next        = MAX_Q;
                load_err_next = 1'b1;
            end else begin
                q_next = load_value;
            end
        end else if (enable) begin
            if (q_illegal) begin
                // Spare codes above MAX_VALUE recover to zero on the next count.
                q_next = ZERO_Q;
            end else if (up_down) begin
                if (!at_max) begin
                    q_next = q_reg + ONE_Q;
                end else if (SATURATE == 0) begin
                    q_next       = ZERO_Q;
                    wrapped_next = 1'b1;
                end
            end else begin
                if (!at_zero) begin
                    q_next = q_reg - ONE_Q;
                end else if (SATURATE == 0) begin
                    q_next       = MAX_Q;
                    wrapped_next = 1'b1;
                end
            end
        end
    end

    // State registers; reset_n acts immediately, independent of clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_reg        <= RST_Q;
            wrapped_reg  <= 1'b0;
            load_err_reg <= 1'b0;
        end else begin
            q_reg        <= q_next;
            wrapped_reg  <= wrapped_next;
            load_err_reg <= load_err_next;
        end
    end

    // terminal looks at the end the counter is heading towards; carry is
    // asserted in saturate mode too so cascades keep a uniform behaviour.
    assign terminal = up_down ? at_max : at_zero;
    assign carry    = enable & terminal;
    assign Q        = q_reg;
    assign wrapped  = wrapped_reg;
    assign load_err = load_err_reg;

endmodule

// File: tb/tb_mod_updown_counter_param.sv
// Bench for mod_updown_counter_param: five instances (wrap, saturate,
// RESET_VALUE=7, and a units/tens cascade) checked every cycle against an
// arithmetic reference model, plus directed sequences with literal values.
module tb_mod_updown_counter_param;

    logic clk;
    logic rst_n;
    logic en, ud, clr, ld, casc_en;
    logic [3:0] lv;

    logic [3:0] q_w, q_s, q_r, q_u;
    logic [2:0] q_t;
    logic t_w, t_s, t_r, t_u, t_t;
    logic c_w, c_s, c_r, c_u, c_t;
    logic w_w, w_s, w_r, w_u, w_t;
    logic e_w, e_s, e_r, e_u, e_t;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_on   = 0;

    mod_updown_counter_param #(.MAX_VALUE(9), .SATURATE(0), .RESET_VALUE(0)) dut_w (
        .clk(clk), .reset_n(rst_n), .enable(en), .up_down(ud), .clear(clr), .load(ld),
        .load_value(lv), .Q(q_w), .terminal(t_w), .carry(c_w), .wrapped(w_w), .load_err(e_w));
    mod_updown_counter_param #(.MAX_VALUE(9), .SATURATE(1), .RESET_VALUE(0)) dut_s (
        .clk(clk), .reset_n(rst_n), .enable(en), .up_down(ud), .clear(clr), .load(ld),
        .load_value(lv), .Q(q_s), .terminal(t_s), .carry(c_s), .wrapped(w_s), .load_err(e_s));
    mod_updown_counter_param #(.MAX_VALUE(9), .SATURATE(0), .RESET_VALUE(7)) dut_r (
        .clk(clk), .reset_n(rst_n), .enable(en), .up_down(ud), .clear(clr), .load(ld),
        .load_value(lv), .Q(q_r), .terminal(t_r), .carry(c_r), .wrapped(w_r), .load_err(e_r));
    mod_updown_counter_param #(.MAX_VALUE(9), .SATURATE(0), .RESET_VALUE(0)) dut_u (
        .clk(clk), .reset_n(rst_n), .enable(casc_en), .up_down(1'b1), .clear(1'b0), .load(1'b0),
        .load_value(4'd0), .Q(q_u), .terminal(t_u), .carry(c_u), .wrapped(w_u), .load_err(e_u));
    mod_updown_counter_param #(.MAX_VALUE(5), .SATURATE(0), .RESET_VALUE(0)) dut_t (
        .clk(clk), .reset_n(rst_n), .enable(c_u), .up_down(1'b1), .clear(1'b0), .load(1'b0),
        .load_value(3'd0), .Q(q_t), .terminal(t_t), .carry(c_t), .wrapped(w_t), .load_err(e_t));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at t=%0t", nm, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [7:0] q;
        logic       w;
        logic       e;
    } st_t;

    localparam int NI = 5;
    int mx  [NI] = '{9, 9, 9, 9, 5};
    int sat [NI] = '{0, 1, 0, 0, 0};
    int rv  [NI] = '{0, 0, 7, 0, 0};
    int mq  [NI];
    bit mw  [NI];
    bit me  [NI];

    function automatic st_t step(input int q, input int m, input int s, input bit c,
                                 input bit l, input int v, input bit e, input bit u);
        st_t r;
        r.q = 8'(q); r.w = 1'b0; r.e = 1'b0;
        if (c) r.q = 8'd0;
        else if (l) begin
            if (v > m) begin r.q = 8'(m); r.e = 1'b1; end
            else r.q = 8'(v);
        end else if (e) begin
            if (s != 0) begin
                if (u) r.q = 8'((q < m) ? q + 1 : q);
                else   r.q = 8'((q > 0) ? q - 1 : q);
            end else begin
                if (u) begin r.q = 8'((q + 1) % (m + 1)); r.w = (q == m); end
                else   begin r.q = 8'((q + m) % (m + 1)); r.w = (q == 0); end
            end
        end
        return r;
    endfunction

    function automatic bit en_of(input int i);
        if (i < 3) return en;
        if (i == 3) return casc_en;
        return casc_en && (mq[3] == 9);
    endfunction

    function automatic bit ud_of(input int i);
        if (i < 3) return ud;
        return 1'b1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NI; i++) begin
                mq[i] <= rv[i]; mw[i] <= 1'b0; me[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                st_t r;
                if (i < 3) r = step(mq[i], mx[i], sat[i], clr, ld, int'(lv), en, ud);
                else       r = step(mq[i], mx[i], sat[i], 1'b0, 1'b0, 0, en_of(i), 1'b1);
                mq[i] <= int'(r.q); mw[i] <= r.w; me[i] <= r.e;
            end
        end
    end

    // Every-cycle comparison of all instances against the model.
    task automatic chk_inst(input int i, input int q, input bit t, input bit c,
                            input bit w, input bit e);
        bit term;
        term = ud_of(i) ? (mq[i] == mx[i]) : (mq[i] == 0);
        chk($sformatf("m%0d_q", i), q, mq[i]);
        chk($sformatf("m%0d_terminal", i), int'(t), int'(term));
        chk($sformatf("m%0d_carry", i), int'(c), int'(term && en_of(i)));
        chk($sformatf("m%0d_wrapped", i), int'(w), int'(mw[i]));
        chk($sformatf("m%0d_load_err", i), int'(e), int'(me[i]));
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk_inst(0, int'(q_w), t_w, c_w, w_w, e_w);
            chk_inst(1, int'(q_s), t_s, c_s, w_s, e_s);
            chk_inst(2, int'(q_r), t_r, c_r, w_r, e_r);
            chk_inst(3, int'(q_u), t_u, c_u, w_u, e_u);
            chk_inst(4, int'(q_t), t_t, c_t, w_t, e_t);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed + random stimulus ----------------
    int exp_w1 [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int exp_s1 [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 9, 9, 9};
    int exp_w2 [4]  = '{1, 0, 9, 8};
    int tens_pulses;

    initial begin
        rst_n = 1'b0; en = 0; ud = 1; clr = 0; ld = 0; lv = 4'd0; casc_en = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_q_w", int'(q_w), 0);
        chk("reset_q_r", int'(q_r), 7);
        chk("reset_flags", int'({w_w, e_w, w_r, e_r}), 0);
        rst_n = 1'b1;
        chk_on = 1'b1;

        // Wrap up (dut_w) and saturate up (dut_s)
        en = 1; ud = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("t1_wrap_q", int'(q_w), exp_w1[i]);
            chk("t1_wrap_pulse", int'(w_w), (i == 9) ? 1 : 0);
            chk("t1_wrap_carry", int'(c_w), (exp_w1[i] == 9) ? 1 : 0);
            chk("t3_sat_q", int'(q_s), exp_s1[i]);
            chk("t3_sat_wrapped", int'(w_s), 0);
        end
        chk("t3_sat_carry", int'(c_s), 1);

        // Wrap down from a loaded 2
        en = 0; ld = 1; lv = 4'd2;
        tick();
        chk("t2_load2", int'(q_w), 2);
        ld = 0; en = 1; ud = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_down_q", int'(q_w), exp_w2[i]);
            chk("t2_down_pulse", int'(w_w), (i == 2) ? 1 : 0);
            chk("t2_terminal", int'(t_w), (exp_w2[i] == 0) ? 1 : 0);
        end

        // Saturate down sticks at 0
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("t3_sat_wrapped_dn", int'(w_s), 0);
        end
        chk("t3_sat_down_q", int'(q_s), 0);
        chk("t3_sat_down_carry", int'(c_s), 1);

        // Priority: clear > load > enable
        en = 0; ld = 1; lv = 4'd5;
        tick();
        chk("t4_load5", int'(q_w), 5);
        clr = 1; ld = 1; lv = 4'd3; en = 1; ud = 1;
        tick();
        chk("t4_clear_wins", int'(q_w), 0);
        clr = 0;
        tick();
        chk("t4_load_over_en", int'(q_w), 3);
        en = 0; lv = 4'd12;
        tick();
        chk("t4_load12_q", int'(q_w), 9);
        chk("t4_load12_err", int'(e_w), 1);
        ld = 0;
        tick();
        chk("t4_err_pulse_end", int'(e_w), 0);
        chk("t4_hold", int'(q_w), 9);

        // Cascade 60 clocks: units then tens
        casc_en = 1; tens_pulses = 0;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (w_t) tens_pulses++;
            if (k == 59) chk("t5_59", int'(q_t) * 10 + int'(q_u), 59);
        end
        chk("t5_00", int'(q_t) * 10 + int'(q_u), 0);
        chk("t5_tens_wrap_count", tens_pulses, 1);
        casc_en = 0;

        // Asynchronous reset mid-cycle at Q=4 with RESET_VALUE=7
        ld = 1; lv = 4'd4; en = 0;
        tick();
        chk("t6_q4", int'(q_r), 4);
        ld = 0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_q", int'(q_r), 7);
        chk("t6_async_flags", int'({w_r, e_r}), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        en = 1; ud = 1;
        tick();
        chk("t6_first_count", int'(q_r), 8);

        // Randomised traffic checked by the model every cycle
        for (int n = 0; n < 400; n++) begin
            clr = ($urandom % 16) == 0;
            ld  = ($urandom % 8) == 0;
            lv  = 4'($urandom % 16);
            en  = ($urandom % 4) != 0;
            ud  = ($urandom % 3) != 0;
            casc_en = ($urandom % 2) == 1;
            if (($urandom % 64) == 0) begin
                #1 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            tick();
        end

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
